// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that serialises one byte at a time from N_REQ
// requesters onto a shared SPI slave MISO line, LSB first. SCLK and CS
// come from an external master and are resynchronised into clk.
module spi_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       CS,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         data_in,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       MISO,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   cur_id
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s;
  logic                   sclk_rise, cs_fall;
  logic [IW-1:0]          last_winner, id_q, winner;
  logic                   found;
  logic [7:0]             shift_reg;
  logic [2:0]             bit_cnt;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev & cs_s;
  assign cs_fall   = cs_prev & ~cs_s;

  // Synchronizer chains plus one extra flop each for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // Round-robin search starting just after the last completed winner
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!found && req[(32'(last_winner) + i) % N_REQ]) begin
        found  = 1'b1;
        winner = IW'((32'(last_winner) + i) % N_REQ);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; abort only counts once at least one bit has gone out
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (found) state_n = LOAD;
      LOAD:  state_n = SHIFT;
      SHIFT: begin
        if (sclk_rise && bit_cnt == 3'd7)   state_n = DONE;
        else if (cs_fall && bit_cnt != '0)  state_n = IDLE;
      end
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: owner id, byte latch, bit counter, round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q        <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      last_winner <= IW'(N_REQ - 1);
    end else begin
      case (state)
        IDLE:  if (found) id_q <= winner;
        LOAD: begin
          shift_reg <= data_in[{id_q, 3'b000} +: 8];
          bit_cnt   <= '0;
        end
        SHIFT: if (sclk_rise) bit_cnt <= bit_cnt + 3'd1;
        DONE:  last_winner <= id_q;
        default: ;
      endcase
    end
  end

  // Moore outputs; bit_cnt wraps on the 8th rise so DONE shows bit 7 explicitly
  always_comb begin
    grant  = '0;
    done   = '0;
    MISO   = 1'b0;
    busy   = (state != IDLE);
    cur_id = (state == IDLE) ? '0 : id_q;
    case (state)
      LOAD:  grant = N_REQ'(1) << id_q;
      SHIFT: MISO  = shift_reg[bit_cnt];
      DONE: begin
        MISO = shift_reg[7];
        done = N_REQ'(1) << id_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench: a table of single-byte transfers plus hand-written
// sequences for abort, CS-low wait, mid-transfer reset and early req drop.
module tb_spi_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        CS = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] data_in = '0;
  logic [2:0]  grant, done;
  logic        MISO, busy;
  logic [1:0]  cur_id;

  int checks = 0;
  int failures = 0;

  logic [2:0] grant_log[$];
  logic [2:0] done_log[$];

  spi_tx_arbiter #(.N_REQ(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .CS(CS), .req(req),
    .data_in(data_in), .grant(grant), .done(done), .MISO(MISO),
    .busy(busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  // Record every grant/done pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (grant != '0) grant_log.push_back(grant);
    if (done != '0)  done_log.push_back(done);
  end

  initial begin
    #300us;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  req;
    logic [23:0] data;
    logic [2:0]  exp_grant;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
    bit          drop;
  } vec_t;

  vec_t tv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output logic [2:0] g, output logic ok);
    ok = 1'b0;
    g  = '0;
    for (int k = 0; k < 80 && !ok; k++) begin
      if (grant_log.size() > 0) begin
        g  = grant_log.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Master behaviour: sample MISO, then raise SCLK (4 clk high, 4 clk low)
  task automatic shift_bits(input int n, output logic [7:0] b);
    b = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      b[k] = MISO;
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_done(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = (done_log.size() > 0) ? done_log.pop_front() : 3'b000;
    check(name, got, exp);
    check({name, "_extra"}, done_log.size(), 0);
  endtask

  initial begin
    logic [2:0] g;
    logic       ok;
    logic [7:0] b;
    logic       steady;
    logic       miso_idle;

    tv[0] = '{3'b111, 24'h33_22_11, 3'b001, 2'd0, 8'h11, 1'b0};
    tv[1] = '{3'b111, 24'h33_22_11, 3'b010, 2'd1, 8'h22, 1'b0};
    tv[2] = '{3'b111, 24'h33_22_11, 3'b100, 2'd2, 8'h33, 1'b0};
    tv[3] = '{3'b111, 24'h33_22_11, 3'b001, 2'd0, 8'h11, 1'b1};
    tv[4] = '{3'b010, 24'h00_A5_00, 3'b010, 2'd1, 8'hA5, 1'b1};
    tv[5] = '{3'b101, 24'h5A_00_3C, 3'b100, 2'd2, 8'h5A, 1'b1};
    tv[6] = '{3'b001, 24'h00_00_80, 3'b001, 2'd0, 8'h80, 1'b1};
    tv[7] = '{3'b110, 24'h77_FF_00, 3'b010, 2'd1, 8'hFF, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_miso", MISO, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_cur_id", cur_id, 0);
    rst_n = 1'b1;

    // Table-driven transfers (first four keep all three requesting)
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      req     = tv[v].req;
      data_in = tv[v].data;
      wait_grant(g, ok);
      check($sformatf("tbl%0d_grant_seen", v), ok, 1);
      check($sformatf("tbl%0d_grant", v), g, tv[v].exp_grant);
      if (tv[v].drop) req = '0;
      @(negedge clk);
      check($sformatf("tbl%0d_cur_id", v), cur_id, tv[v].exp_id);
      check($sformatf("tbl%0d_busy", v), busy, 1);
      shift_bits(8, b);
      check($sformatf("tbl%0d_byte", v), b, tv[v].exp_byte);
      check_done($sformatf("tbl%0d_done", v), tv[v].exp_grant);
      if (tv[v].drop) check($sformatf("tbl%0d_idle_busy", v), busy, 0);
    end

    // Abort after 3 bits: requester 2 must win again over requester 0
    @(negedge clk);
    req = 3'b100;
    data_in = 24'hF0_00_00;
    wait_grant(g, ok);
    check("abort_grant1", g, 3'b100);
    shift_bits(3, b);
    req = 3'b101;
    @(negedge clk);
    CS = 1'b0;
    ok = 1'b0;
    miso_idle = 1'b1;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        miso_idle = MISO;
      end
    end
    check("abort_to_idle", ok, 1);
    check("abort_idle_miso", miso_idle, 0);
    wait_grant(g, ok);
    check("abort_grant2", g, 3'b100);
    check("abort_no_done", done_log.size(), 0);
    req = '0;
    @(negedge clk);
    CS = 1'b1;
    repeat (4) @(negedge clk);
    shift_bits(8, b);
    check("abort_retry_byte", b, 8'hF0);
    check_done("abort_retry_done", 3'b100);

    // CS held low for 50 cycles; SCLK toggles must be ignored
    @(negedge clk);
    CS = 1'b0;
    req = 3'b001;
    data_in = 24'h00_00_B7;
    wait_grant(g, ok);
    check("wait_grant", g, 3'b001);
    req = '0;
    steady = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      SCLK = ((k % 10) >= 5);
      if (busy !== 1'b1 || MISO !== 1'b1 || done !== 3'b000) steady = 1'b0;
    end
    SCLK = 1'b0;
    check("wait_steady", steady, 1);
    check("wait_no_done", done_log.size(), 0);
    CS = 1'b1;
    repeat (4) @(negedge clk);
    shift_bits(8, b);
    check("wait_byte", b, 8'hB7);
    check_done("wait_done", 3'b001);

    // Reset after 5 bits of 0xC3; pointer resets so requester 0 goes first
    @(negedge clk);
    req = 3'b011;
    data_in = 24'h00_C3_5E;
    wait_grant(g, ok);
    check("rst_seq_grant1", g, 3'b010);
    shift_bits(5, b);
    check("rst_seq_partial", b[4:0], 5'b00011);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_seq_miso", MISO, 0);
    check("rst_seq_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_seq_grant_at_release", grant, 0);
    wait_grant(g, ok);
    check("rst_seq_grant2", g, 3'b001);
    req = '0;
    check("rst_seq_no_done", done_log.size(), 0);
    shift_bits(8, b);
    check("rst_seq_byte", b, 8'h5E);
    check_done("rst_seq_done", 3'b001);

    // req dropped and data changed one cycle after grant
    @(negedge clk);
    req = 3'b010;
    data_in = 24'h00_6D_00;
    wait_grant(g, ok);
    check("drop_grant", g, 3'b010);
    @(negedge clk);
    req = '0;
    data_in = '0;
    shift_bits(8, b);
    check("drop_byte", b, 8'h6D);
    check_done("drop_done", 3'b010);
    check("drop_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
